// File: rtl/uart_tx_fifo.sv
// Transmit-side byte FIFO that drains into a UART transmitter one byte at a time.
// A one-cycle write strobe is followed by a hold-off window before tx_ready is trusted again.
module uart_tx_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned HOLDOFF    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  tx_ready,
  output logic                  uart_wr,
  output logic [7:0]            uart_din,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  empty
);

  localparam int unsigned         DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_ONE   = 1;
  localparam logic [7:0]          HOLD_INIT = 8'(HOLDOFF - 1);

  typedef enum logic [1:0] {S_IDLE, S_STROBE, S_HOLD, S_WAIT} state_t;

  state_t              state_q;
  logic [7:0]          mem_q [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0] rd_ptr_q;
  logic [7:0]          hold_q;
  logic                uart_wr_q;
  logic [7:0]          uart_din_q;
  logic                full, push, pop;

  // Extra wrap bit distinguishes full from empty when the low bits match.
  assign full     = (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]) &&
                    (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]);
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign in_ready = !full;
  assign level    = wr_ptr_q - rd_ptr_q;
  assign push     = in_valid && !full;
  assign pop      = (state_q == S_IDLE) && !empty && tx_ready;
  assign uart_wr  = uart_wr_q;
  assign uart_din = uart_din_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wr_ptr_q <= '0;
    else     wr_ptr_q <= wr_ptr_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rd_ptr_q   <= '0;
      hold_q     <= '0;
      uart_wr_q  <= 1'b0;
      uart_din_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            uart_din_q <= mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
            rd_ptr_q   <= rd_ptr_q + PTR_ONE;
            uart_wr_q  <= 1'b1;
            state_q    <= S_STROBE;
          end
        end
        S_STROBE: begin
          uart_wr_q <= 1'b0;
          hold_q    <= HOLD_INIT;
          state_q   <= S_HOLD;
        end
        S_HOLD: begin
          if (hold_q == '0) state_q <= S_WAIT;
          else              hold_q  <= hold_q - 8'd1;
        end
        S_WAIT: begin
          if (tx_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
